// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: load/store initiator for the data memory; sub-word stores use
// read-modify-write, sub-word loads are sign/zero extended, bad requests never touch dm.
module dm_access_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_ctrl_r,
  output logic              dm_ctrl_w,
  output logic [31:0]       dm_wdata,
  input  logic [31:0]       dm_rdata
);
  typedef enum logic [2:0] {IDLE, ERR, LD_RD, LD_CAP, WR, RMW_RD, RMW_MERGE, RMW_WR} state_t;
  state_t            r_state;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [1:0]        r_off;
  logic [15:0]       r_wdata;
  logic              r_resp_valid;
  logic              r_resp_err;
  logic [31:0]       r_resp_rdata;
  logic [ADDR_W-1:0] r_dm_addr;
  logic              r_dm_r;
  logic              r_dm_w;
  logic [31:0]       r_dm_wdata;
  logic              w_err;
  logic [4:0]        w_sh;
  logic [31:0]       w_lane;
  logic [31:0]       w_load;
  logic [31:0]       w_mask;
  logic [31:0]       w_merged;
  assign w_err = (req_size == 2'b11) | ((req_size == 2'b01) & req_addr[0]) |
                 ((req_size == 2'b10) & (|req_addr[1:0]));
  assign w_sh = {r_off, 3'b000};
  assign w_lane = dm_rdata >> w_sh;
  always_comb begin
    w_load = r_size == 2'b00 ? {{24{r_signed & w_lane[7]}}, w_lane[7:0]} :
             r_size == 2'b01 ? {{16{r_signed & w_lane[15]}}, w_lane[15:0]} : dm_rdata;
    w_mask = (r_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    w_merged = (dm_rdata & ~w_mask) | (({16'h0, r_wdata} << w_sh) & w_mask);
  end
  assign req_ready  = r_state == IDLE;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign dm_addr    = r_dm_addr;
  assign dm_ctrl_r  = r_dm_r;
  assign dm_ctrl_w  = r_dm_w;
  assign dm_wdata   = r_dm_wdata;
  // Strobes are registers so async reset drops them at once, cancelling any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_size       <= '0;
      r_signed     <= 1'b0;
      r_off        <= '0;
      r_wdata      <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_dm_addr    <= '0;
      r_dm_r       <= 1'b0;
      r_dm_w       <= 1'b0;
      r_dm_wdata   <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_size   <= req_size;
          r_signed <= req_signed;
          r_off    <= req_addr[1:0];
          r_wdata  <= req_wdata[15:0];
          if (w_err) r_state <= ERR;
          else begin
            r_dm_addr <= {req_addr[ADDR_W-1:2], 2'b00};
            if (!req_we) begin
              r_dm_r  <= 1'b1;
              r_state <= LD_RD;
            end else if (req_size == 2'b10) begin
              r_dm_w     <= 1'b1;
              r_dm_wdata <= req_wdata;
              r_state    <= WR;
            end else begin
              r_dm_r  <= 1'b1;
              r_state <= RMW_RD;
            end
          end
        end
        ERR: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b1;
          r_resp_rdata <= '0;
          r_state      <= IDLE;
        end
        LD_RD: begin
          r_dm_r  <= 1'b0;
          r_state <= LD_CAP;
        end
        LD_CAP: begin
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= w_load;
          r_state      <= IDLE;
        end
        WR: begin
          r_dm_w       <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= IDLE;
        end
        RMW_RD: begin
          r_dm_r  <= 1'b0;
          r_state <= RMW_MERGE;
        end
        RMW_MERGE: begin
          r_dm_wdata <= w_merged;
          r_dm_w     <= 1'b1;
          r_state    <= RMW_WR;
        end
        RMW_WR: begin
          r_dm_w       <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= '0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
